// File: rtl/lfsr_hex_display.sv
// Button-stepped WIDTH-bit Fibonacci LFSR with load, lockup guard and seven-segment hex output.
// Define AUTO_RUN_EN to add a periodic auto-step counter gated by auto_en.
module lfsr_hex_display #(
    parameter int unsigned       WIDTH           = 8,
    parameter logic [WIDTH-1:0]  TAPS            = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0]  SEED            = WIDTH'(1),
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter int unsigned       AUTO_PERIOD     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic                   auto_en,
    output logic [WIDTH-1:0]       state,
    output logic                   step_pulse,
    output logic [7*(WIDTH/4)-1:0] seg
);

    localparam int unsigned     DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_level_q, db_level_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             btn_req_q, btn_req_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             auto_req;
    logic             step_req;
    logic             feedback;

    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        btn_req_d  = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            db_level_d = sync2_q;
            db_cnt_d   = '0;
            // Only a debounced press (0->1) requests a step.
            btn_req_d  = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            btn_req_q  <= 1'b0;
            state_q    <= SEED;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            btn_req_q  <= btn_req_d;
            state_q    <= state_d;
        end
    end

`ifdef AUTO_RUN_EN
    localparam int unsigned      AutoW    = $clog2(AUTO_PERIOD);
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PERIOD - 1);

    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;

    assign auto_req = auto_en && (auto_cnt_q == AutoLast);

    always_comb begin
        auto_cnt_d = auto_cnt_q + 1'b1;
        if (load || !auto_en || auto_req) begin
            auto_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
    assign auto_req       = 1'b0;
`endif

    // Coincident button and auto requests merge into a single step.
    assign step_req = btn_req_q | auto_req;
    assign feedback = ^(state_q & TAPS);

    always_comb begin
        state_d    = state_q;
        step_pulse = 1'b0;
        if (state_q == '0) begin
            state_d = SEED;
        end else if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step_req) begin
            state_d    = {feedback, state_q[WIDTH-1:1]};
            step_pulse = 1'b1;
        end
    end

    assign state = state_q;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    for (genvar k = 0; k < WIDTH / 4; k++) begin : g_digit
        assign seg[7*k +: 7] = hex_glyph(state_q[4*k +: 4]);
    end

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Directed bench for lfsr_hex_display: default 8-bit build plus a 16-bit instance.
module tb_lfsr_hex_display;

    logic        clk = 1'b0;
    logic        rst, btn, load, auto_en, btn_w;
    logic [7:0]  load_val, state;
    logic        step_pulse;
    logic [13:0] seg;
    logic [15:0] state_w;
    logic        step_w;
    logic [27:0] seg_w;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int run_len = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    lfsr_hex_display dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .load       (load),
        .load_val   (load_val),
        .auto_en    (auto_en),
        .state      (state),
        .step_pulse (step_pulse),
        .seg        (seg)
    );

    lfsr_hex_display #(
        .WIDTH (16),
        .TAPS  (16'hB400),
        .SEED  (16'hACE1)
    ) dut_w (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn_w),
        .load       (1'b0),
        .load_val   (16'h0000),
        .auto_en    (1'b0),
        .state      (state_w),
        .step_pulse (step_w),
        .seg        (seg_w)
    );

    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            pulse_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold, input int rel);
        btn = 1'b1;
        repeat (hold) tick();
        btn = 1'b0;
        repeat (rel) tick();
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        int n;
        int base;

        exp_seq[0] = 8'h40;
        exp_seq[1] = 8'h20;
        exp_seq[2] = 8'h10;
        exp_seq[3] = 8'h88;

        rst = 1'b0; btn = 1'b0; load = 1'b0; load_val = 8'h00; auto_en = 1'b0; btn_w = 1'b0;
        tick();
        tick();
        check("reset_state", 32'(state), 32'h01);
        check("reset_seg", 32'(seg), 32'(14'b0000001_1001111));
        check("reset_pulse", 32'(step_pulse), 32'h0);
        rst = 1'b1;
        tick();
        check("wide_reset_state", 32'(state_w), 32'hACE1);
        check("wide_reset_digit3", 32'(seg_w[27:21]), 32'(7'b0001000));

        // First press: measure latency, then finish the 10-high/10-low press.
        base = pulse_cnt;
        btn  = 1'b1;
        n    = 0;
        while (step_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("press_latency", 32'(n), 32'd6);
        repeat (10 - n) tick();
        btn = 1'b0;
        repeat (10) tick();
        check("step1", 32'(state), 32'h80);
        for (int i = 0; i < 4; i++) begin
            press(10, 10);
            check($sformatf("step%0d", i + 2), 32'(state), 32'(exp_seq[i]));
        end
        check("five_pulses", 32'(pulse_cnt - base), 32'd5);

        press(3, 12);
        check("glitch_state", 32'(state), 32'h88);
        check("glitch_pulses", 32'(pulse_cnt - base), 32'd5);

        press(200, 12);
        check("hold_state", 32'(state), 32'hC4);
        check("hold_pulses", 32'(pulse_cnt - base), 32'd6);

        load_val = 8'hA5; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_state", 32'(state), 32'hA5);
        check("load_digit1", 32'(seg[13:7]), 32'(7'b0001000));
        check("load_digit0", 32'(seg[6:0]), 32'(7'b0100100));

        load_val = 8'h00; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_zero_guard", 32'(state), 32'h01);

        // Load lands in the cycle the debounced press would step.
        load_val = 8'h3C;
        btn = 1'b1;
        repeat (6) tick();
        load = 1'b1;
        #1;
        check("coincide_pulse", 32'(step_pulse), 32'h0);
        tick();
        load = 1'b0;
        check("coincide_state", 32'(state), 32'h3C);
        repeat (4) tick();
        btn = 1'b0;
        repeat (12) tick();
        check("coincide_dropped", 32'(state), 32'h3C);
        check("coincide_pulses", 32'(pulse_cnt - base), 32'd6);

        btn_w = 1'b1;
        repeat (10) tick();
        btn_w = 1'b0;
        repeat (10) tick();
        check("wide_step", 32'(state_w), 32'hD670);
        check("wide_digit3", 32'(seg_w[27:21]), 32'(7'b1000010));
        check("wide_digit0", 32'(seg_w[6:0]), 32'(7'b0000001));

        // Reset in the middle of a debounce.
        btn = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("midreset_state", 32'(state), 32'h01);
        check("midreset_pulse", 32'(step_pulse), 32'h0);
        rst = 1'b1;
        btn = 1'b0;
        repeat (15) tick();
        check("midreset_nostep", 32'(state), 32'h01);
        check("midreset_pulses", 32'(pulse_cnt - base), 32'd6);

        check("single_cycle_pulses", 32'(max_run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
